// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: FSM encoding, command-byte
// bit positions, default register count and a saturating counter helper.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_ABORT
  } state_e;

  localparam int unsigned CMD_LONG_BIT  = 7;
  localparam int unsigned CMD_READ_BIT  = 6;
  localparam int unsigned CMD_SEC_BIT   = 5;
  localparam int unsigned DEFAULT_NREGS = 32;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Bundle of the SPI-side and register-file-side signals of spi_cmd_decoder.
// master = SPI slave / register file side, slave = the decoder itself.
interface spi_cmd_decoder_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              frame_active;
  logic [7:0]        tx_data;
  logic              tx_ack;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr_en;
  logic [7:0]        reg_rdata;
  logic              err;
  logic              busy;

  modport master (
    output rx_data, rx_valid, frame_active, tx_ack, reg_rdata,
    input  tx_data, reg_addr, reg_wdata, reg_wr_en, err, busy
  );

  modport slave (
    input  rx_data, rx_valid, frame_active, tx_ack, reg_rdata,
    output tx_data, reg_addr, reg_wdata, reg_wr_en, err, busy
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command-frame decoder driving a small register file (short/long, read/write).
// Optional macro SPI_CMD_ERR_CNT_EN adds a saturating err_count output.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned NREGS  = DEFAULT_NREGS,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              frame_active,
  output logic [7:0]        tx_data,
  input  logic              tx_ack,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr_en,
  input  logic [7:0]        reg_rdata,
  output logic              err,
  output logic              busy
`ifdef SPI_CMD_ERR_CNT_EN
  ,output logic [7:0]       err_count
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NREGS - 1);

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_MAX) ? '0 : a + ADDR_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic              fa_q, fa_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_wr_en_q, reg_wr_en_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [5:0]        remaining_q, remaining_d;
  logic              is_read_q, is_read_d;
  logic              reading_q, reading_d;
  logic              load_q, load_d;
`ifdef SPI_CMD_ERR_CNT_EN
  logic [7:0]        err_count_q, err_count_d;
`endif

  always_comb begin
    state_d     = state_q;
    fa_d        = frame_active;
    tx_data_d   = tx_data_q;
    // A write strobe shows the address it targets; advance only once it has been issued.
    reg_addr_d  = reg_wr_en_q ? addr_inc(reg_addr_q) : reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_en_d = 1'b0;
    err_d       = 1'b0;
    remaining_d = remaining_q;
    is_read_d   = is_read_q;
    reading_d   = reading_q;
    load_d      = 1'b0;

    if (load_q && reading_q) tx_data_d = reg_rdata;

    // Frame end overrides everything, including an rx_valid in the same cycle.
    if (state_q != ST_IDLE && !frame_active) begin
      state_d     = ST_IDLE;
      err_d       = (remaining_q != 6'd0);
      remaining_d = 6'd0;
      reading_d   = 1'b0;
      tx_data_d   = 8'h00;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tx_data_d = 8'h00;
          if (frame_active && !fa_q) state_d = ST_CMD;
        end
        ST_CMD: if (rx_valid) begin
          reg_addr_d = rx_data[ADDR_W-1:0];
          is_read_d  = rx_data[CMD_READ_BIT];
          if (rx_data[CMD_LONG_BIT]) begin
            state_d = ST_LEN;
          end else begin
            state_d     = ST_DATA;
            remaining_d = 6'd1;
            reading_d   = rx_data[CMD_READ_BIT];
            load_d      = rx_data[CMD_READ_BIT];
          end
        end
        ST_LEN: if (rx_valid) begin
          state_d     = ST_DATA;
          remaining_d = (rx_data[4:0] == 5'd0) ? 6'd32 : {1'b0, rx_data[4:0]};
          reading_d   = is_read_q;
          load_d      = is_read_q;
        end
        ST_DATA: begin
          if (is_read_q) begin
            if (tx_ack) begin
              reg_addr_d  = addr_inc(reg_addr_q);
              remaining_d = remaining_q - 6'd1;
              if (remaining_q == 6'd1) begin
                state_d   = ST_DONE;
                reading_d = 1'b0;
                tx_data_d = 8'h00;
              end else begin
                load_d = 1'b1;
              end
            end
          end else if (rx_valid) begin
            reg_wdata_d = rx_data;
            reg_wr_en_d = 1'b1;
            remaining_d = remaining_q - 6'd1;
            if (remaining_q == 6'd1) state_d = ST_DONE;
          end
        end
        ST_DONE: if (rx_valid) begin
          err_d   = 1'b1;
          state_d = ST_ABORT;
        end
        ST_ABORT: if (rx_valid) err_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
`ifdef SPI_CMD_ERR_CNT_EN
    err_count_d = err_d ? sat_inc8(err_count_q) : err_count_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fa_q        <= 1'b0;
      tx_data_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_en_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
      is_read_q   <= 1'b0;
      reading_q   <= 1'b0;
      load_q      <= 1'b0;
`ifdef SPI_CMD_ERR_CNT_EN
      err_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fa_q        <= fa_d;
      tx_data_q   <= tx_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_en_q <= reg_wr_en_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      remaining_q <= remaining_d;
      is_read_q   <= is_read_d;
      reading_q   <= reading_d;
      load_q      <= load_d;
`ifdef SPI_CMD_ERR_CNT_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = reg_wr_en_q;
  assign err       = err_q;
  assign busy      = busy_q;
`ifdef SPI_CMD_ERR_CNT_EN
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder; SPI_CMD_ERR_CNT_EN enables
// the err_count scenario.
module tb_spi_cmd_decoder;
  import spi_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_cmd_decoder_if #(.ADDR_W(5)) bus ();

  logic [7:0] regs [32];
  assign bus.reg_rdata = regs[bus.reg_addr];

`ifdef SPI_CMD_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  spi_cmd_decoder #(.NREGS(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (bus.rx_data),
    .rx_valid     (bus.rx_valid),
    .frame_active (bus.frame_active),
    .tx_data      (bus.tx_data),
    .tx_ack       (bus.tx_ack),
    .reg_addr     (bus.reg_addr),
    .reg_wdata    (bus.reg_wdata),
    .reg_wr_en    (bus.reg_wr_en),
    .reg_rdata    (bus.reg_rdata),
    .err          (bus.err),
    .busy         (bus.busy)
`ifdef SPI_CMD_ERR_CNT_EN
    ,.err_count   (err_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Write/err log captured on the falling edge, away from DUT updates.
  logic [4:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  int wr_n  = 0;
  int err_n = 0;

  always @(negedge clk) begin
    if (bus.reg_wr_en) begin
      if (wr_n < 64) begin
        wr_addr_log[wr_n] = bus.reg_addr;
        wr_data_log[wr_n] = bus.reg_wdata;
      end
      wr_n++;
    end
    if (bus.err) err_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap();
    tick(); tick(); tick();
  endtask

  task automatic frame_begin();
    bus.frame_active = 1'b1;
    tick(); tick();
  endtask

  task automatic frame_end();
    bus.frame_active = 1'b0;
    tick(); tick();
  endtask

  task automatic clear_log();
    wr_n  = 0;
    err_n = 0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    n_checks++; if (bus.reg_addr !== 5'd0) begin n_fail++; $display("FAIL reset_reg_addr: got %0d expected 0", bus.reg_addr); end
    n_checks++; if (bus.reg_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_reg_wdata: got %h expected 00", bus.reg_wdata); end
    n_checks++; if (bus.reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.reg_wr_en); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    clear_log();
    bus.tx_ack = 1'b1;
    send_byte(8'h55);
    bus.tx_ack = 1'b0;
    gap();
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL idle_no_write: got %0d expected 0", wr_n); end
    n_checks++; if (err_n !== 0) begin n_fail++; $display("FAIL idle_no_err: got %0d expected 0", err_n); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_short_write();
    clear_log();
    frame_begin();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy: got %b expected 1", bus.busy); end
    send_byte(8'h03); gap();
    send_byte(8'hA5);
    n_checks++; if (bus.reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL sw_wr_en: got %b expected 1", bus.reg_wr_en); end
    n_checks++; if (bus.reg_addr !== 5'd3) begin n_fail++; $display("FAIL sw_addr: got %0d expected 3", bus.reg_addr); end
    n_checks++; if (bus.reg_wdata !== 8'hA5) begin n_fail++; $display("FAIL sw_wdata: got %h expected a5", bus.reg_wdata); end
    tick();
    n_checks++; if (bus.reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL sw_wr_one_cycle: got %b expected 0", bus.reg_wr_en); end
    gap();
    frame_end();
    n_checks++; if (wr_n !== 1) begin n_fail++; $display("FAIL sw_write_count: got %0d expected 1", wr_n); end
    n_checks++; if (err_n !== 0) begin n_fail++; $display("FAIL sw_err: got %0d expected 0", err_n); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sw_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_long_write();
    logic [4:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    clear_log();
    frame_begin();
    send_byte(8'h9E); gap();
    send_byte(8'h03); gap();
    send_byte(8'h11); gap();
    send_byte(8'h22); gap();
    send_byte(8'h33); gap();
    n_checks++; if (err_n !== 0) begin n_fail++; $display("FAIL lw_no_err_yet: got %0d expected 0", err_n); end
    send_byte(8'h44); gap();
    n_checks++; if (err_n !== 1) begin n_fail++; $display("FAIL lw_extra_err: got %0d expected 1", err_n); end
    frame_end();
    n_checks++; if (wr_n !== 3) begin n_fail++; $display("FAIL lw_write_count: got %0d expected 3", wr_n); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (wr_addr_log[i] !== exp_a[i]) begin n_fail++; $display("FAIL lw_addr[%0d]: got %0d expected %0d", i, wr_addr_log[i], exp_a[i]); end
      n_checks++; if (wr_data_log[i] !== exp_d[i]) begin n_fail++; $display("FAIL lw_data[%0d]: got %h expected %h", i, wr_data_log[i], exp_d[i]); end
    end
    n_checks++; if (err_n !== 1) begin n_fail++; $display("FAIL lw_err_total: got %0d expected 1", err_n); end
  endtask

  task automatic test_long_read();
    clear_log();
    regs[4] = 8'h5A;
    regs[5] = 8'hC3;
    frame_begin();
    send_byte(8'hC4); gap();
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL lr_tx_before: got %h expected 00", bus.tx_data); end
    send_byte(8'h02); tick();
    n_checks++; if (bus.tx_data !== 8'h5A) begin n_fail++; $display("FAIL lr_tx_first: got %h expected 5a", bus.tx_data); end
    gap();
    bus.tx_ack = 1'b1; tick(); bus.tx_ack = 1'b0;
    tick(); tick();
    n_checks++; if (bus.tx_data !== 8'hC3) begin n_fail++; $display("FAIL lr_tx_second: got %h expected c3", bus.tx_data); end
    gap();
    bus.tx_ack = 1'b1; tick(); bus.tx_ack = 1'b0;
    tick();
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL lr_tx_done: got %h expected 00", bus.tx_data); end
    frame_end();
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL lr_no_write: got %0d expected 0", wr_n); end
    n_checks++; if (err_n !== 0) begin n_fail++; $display("FAIL lr_no_err: got %0d expected 0", err_n); end
  endtask

  task automatic test_read_wrap();
    clear_log();
    regs[31] = 8'h7E;
    regs[0]  = 8'h81;
    frame_begin();
    send_byte(8'hDF); gap();
    send_byte(8'h02); tick();
    n_checks++; if (bus.tx_data !== 8'h7E) begin n_fail++; $display("FAIL wrap_tx_first: got %h expected 7e", bus.tx_data); end
    bus.tx_ack = 1'b1; tick(); bus.tx_ack = 1'b0;
    tick(); tick();
    n_checks++; if (bus.reg_addr !== 5'd0) begin n_fail++; $display("FAIL wrap_addr: got %0d expected 0", bus.reg_addr); end
    n_checks++; if (bus.tx_data !== 8'h81) begin n_fail++; $display("FAIL wrap_tx_second: got %h expected 81", bus.tx_data); end
    bus.tx_ack = 1'b1; tick(); bus.tx_ack = 1'b0;
    frame_end();
    n_checks++; if (err_n !== 0) begin n_fail++; $display("FAIL wrap_err: got %0d expected 0", err_n); end
  endtask

  task automatic test_abort();
    clear_log();
    frame_begin();
    send_byte(8'h80); gap();
    send_byte(8'h00); gap();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h10 + 8'(i)); gap();
    end
    n_checks++; if (err_n !== 0) begin n_fail++; $display("FAIL abort_err_early: got %0d expected 0", err_n); end
    // Frame drops in the same cycle as a sixth byte: no write may result.
    bus.frame_active = 1'b0;
    send_byte(8'hEE);
    tick(); tick();
    n_checks++; if (wr_n !== 5) begin n_fail++; $display("FAIL abort_write_count: got %0d expected 5", wr_n); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (wr_addr_log[i] !== 5'(i)) begin n_fail++; $display("FAIL abort_addr[%0d]: got %0d expected %0d", i, wr_addr_log[i], i); end
      n_checks++; if (wr_data_log[i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL abort_data[%0d]: got %h expected %h", i, wr_data_log[i], 8'h10 + 8'(i)); end
    end
    n_checks++; if (err_n !== 1) begin n_fail++; $display("FAIL abort_err: got %0d expected 1", err_n); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_midframe();
    clear_log();
    frame_begin();
    send_byte(8'h81); gap();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.reg_addr !== 5'd0) begin n_fail++; $display("FAIL rm_addr: got %0d expected 0", bus.reg_addr); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rm_tx_data: got %h expected 00", bus.tx_data); end
    n_checks++; if (bus.reg_wr_en !== 1'b0 || bus.err !== 1'b0 || bus.reg_wdata !== 8'h00) begin
      n_fail++; $display("FAIL rm_outputs: got wr_en=%b err=%b wdata=%h expected 0 0 00", bus.reg_wr_en, bus.err, bus.reg_wdata);
    end
`ifdef SPI_CMD_ERR_CNT_EN
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rm_err_count: got %0d expected 0", err_count); end
`endif
    bus.frame_active = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    frame_begin();
    send_byte(8'h02); gap();
    send_byte(8'h3C);
    n_checks++; if (bus.reg_wr_en !== 1'b1 || bus.reg_addr !== 5'd2 || bus.reg_wdata !== 8'h3C) begin
      n_fail++; $display("FAIL rm_next_frame: got wr_en=%b addr=%0d wdata=%h expected 1 2 3c", bus.reg_wr_en, bus.reg_addr, bus.reg_wdata);
    end
    gap();
    frame_end();
    n_checks++; if (wr_n !== 1) begin n_fail++; $display("FAIL rm_write_count: got %0d expected 1", wr_n); end
    n_checks++; if (err_n !== 0) begin n_fail++; $display("FAIL rm_err: got %0d expected 0", err_n); end
  endtask

`ifdef SPI_CMD_ERR_CNT_EN
  task automatic test_err_count();
    clear_log();
    frame_begin();
    send_byte(8'h00); tick();
    send_byte(8'h01); tick();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'hFF); tick();
    end
    n_checks++; if (err_count !== 8'd10) begin n_fail++; $display("FAIL errcnt_10: got %0d expected 10", err_count); end
    for (int i = 0; i < 290; i++) begin
      send_byte(8'hFF); tick();
    end
    n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL errcnt_sat: got %0d expected 255", err_count); end
    n_checks++; if (err_n !== 300) begin n_fail++; $display("FAIL errcnt_pulses: got %0d expected 300", err_n); end
    frame_end();
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 8'(i * 7);
    rst              = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.frame_active = 1'b0;
    bus.tx_ack       = 1'b0;

    test_reset();
    test_idle_ignore();
    test_short_write();
    test_long_write();
    test_long_read();
    test_read_wrap();
    test_abort();
    test_reset_midframe();
`ifdef SPI_CMD_ERR_CNT_EN
    test_err_count();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
